// File: rtl/softmax_normalizer_pkg.sv
// Shared types and width helpers for the softmax normalizer slice.
package softmax_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DIVIDE  = 2'd1,
        EMIT    = 2'd2
    } softmax_state_t;

    // 1.0 in Q4.12, also the ceiling for any emitted probability
    localparam logic [15:0] ONE_Q412 = 16'h1000;

    // Accumulator must hold VEC_LEN full-scale samples without overflow
    function automatic int calc_sum_width(input int bit_width, input int vec_len);
        return bit_width + $clog2(vec_len);
    endfunction

    // 2^(2*FRAC_BITS) needs 2*FRAC_BITS+1 quotient bits when the divisor is 1
    function automatic int calc_recip_width(input int frac_bits);
        return 2 * frac_bits + 1;
    endfunction

endpackage

// File: rtl/softmax_normalizer_if.sv
// Stream signals between the exp stage, the normalizer and the consumer.
interface softmax_normalizer_if #(
    parameter int BIT_WIDTH = 16
);
    logic                        i_valid;
    logic signed [BIT_WIDTH-1:0] i_exp;
    logic                        o_in_ready;
    logic                        o_drop;
    logic        [BIT_WIDTH-1:0] o_prob;
    logic                        o_valid;
    logic                        o_last;
    logic                        i_ready;

    modport slave (
        input  i_valid, i_exp, i_ready,
        output o_in_ready, o_drop, o_prob, o_valid, o_last
    );

    modport master (
        output i_valid, i_exp, i_ready,
        input  o_in_ready, o_drop, o_prob, o_valid, o_last
    );
endinterface

// File: rtl/softmax_normalizer_recip_divider.sv
// Restoring bit-serial divider producing floor(2^(RECIP_WIDTH-1) / divisor),
// one quotient bit per cycle, MSB first. A zero divisor yields zero.
module recip_divider
    import softmax_pkg::*;
#(
    parameter int SUM_WIDTH   = calc_sum_width(16, 8),
    parameter int RECIP_WIDTH = calc_recip_width(12)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   start_i,
    input  logic [SUM_WIDTH-1:0]   divisor_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [RECIP_WIDTH-1:0] quotient_o
);
    localparam int STEP_W = $clog2(RECIP_WIDTH);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(RECIP_WIDTH - 1);

    logic [SUM_WIDTH-1:0]   div_q;
    logic [SUM_WIDTH-1:0]   rem_q, rem_d;
    logic [RECIP_WIDTH-1:0] quo_q, quo_d;
    logic [STEP_W-1:0]      step_q;
    logic                   busy_q;
    logic [SUM_WIDTH:0]     rem_shift;
    logic                   fits;

    // One restoring step; the dividend is a single 1 in its MSB, so only
    // step 0 shifts in a one.
    always_comb begin
        rem_shift = {rem_q, (step_q == '0)};
        fits      = rem_shift >= {1'b0, div_q};
        rem_d     = fits ? SUM_WIDTH'(rem_shift - {1'b0, div_q}) : rem_shift[SUM_WIDTH-1:0];
        quo_d     = busy_q ? {quo_q[RECIP_WIDTH-2:0], fits} : quo_q;
    end

    // The final quotient is exposed during the last step so the caller can
    // consume it on the same edge that completes the division.
    assign busy_o     = busy_q;
    assign done_o     = busy_q && (step_q == LAST_STEP);
    assign quotient_o = (div_q == '0) ? '0 : quo_d;

    // Divider state: load on start, then step until the last quotient bit
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            div_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            step_q <= '0;
            busy_q <= 1'b0;
        end else if (start_i) begin
            div_q  <= divisor_i;
            rem_q  <= '0;
            quo_q  <= '0;
            step_q <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            step_q <= step_q + 1'b1;
            if (step_q == LAST_STEP) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/softmax_normalizer.sv
// Collects a vector of Q4.12 exponentials, divides 1.0 by their sum and
// streams each element scaled by the reciprocal as a Q4.12 probability.
module softmax_normalizer
    import softmax_pkg::*;
#(
    parameter int BIT_WIDTH   = 16,
    parameter int FRAC_BITS   = 12,
    parameter int VEC_LEN     = 8,
    parameter int SUM_WIDTH   = calc_sum_width(BIT_WIDTH, VEC_LEN),
    parameter int RECIP_WIDTH = calc_recip_width(FRAC_BITS)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    softmax_normalizer_if.slave  bus
);
    localparam int CNT_W  = $clog2(VEC_LEN);
    localparam int PROD_W = BIT_WIDTH + RECIP_WIDTH;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VEC_LEN - 1);

    softmax_state_t         state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       idx_q;
    logic [SUM_WIDTH-1:0]   sum_q, sum_d;
    logic [BIT_WIDTH-1:0]   vec_buf_q [VEC_LEN];
    logic [RECIP_WIDTH-1:0] recip_q;
    logic                   in_ready_q, drop_q, valid_q, last_q;
    logic [BIT_WIDTH-1:0]   prob_q, prob_d;

    logic [BIT_WIDTH-1:0]   exp_clamped;
    logic                   accept, last_accept, handshake;
    logic [CNT_W-1:0]       sel_idx;
    logic [RECIP_WIDTH-1:0] recip_sel;
    logic [PROD_W-1:0]      prod, scaled;

    logic                   div_busy, div_done;
    logic [RECIP_WIDTH-1:0] div_quotient;

    // Divisor is the sum including the element accepted on the start edge
    recip_divider #(
        .SUM_WIDTH   (SUM_WIDTH),
        .RECIP_WIDTH (RECIP_WIDTH)
    ) u_recip_divider (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .start_i    (last_accept),
        .divisor_i  (sum_d),
        .busy_o     (div_busy),
        .done_o     (div_done),
        .quotient_o (div_quotient)
    );

    // Input clamping, accumulation and the shared scale/saturate datapath.
    // On the DIVIDE->EMIT edge the fresh quotient scales element 0; in EMIT
    // the stored reciprocal scales the next element.
    always_comb begin
        exp_clamped = bus.i_exp[BIT_WIDTH-1] ? '0 : $unsigned(bus.i_exp);
        sum_d       = sum_q + SUM_WIDTH'(exp_clamped);
        accept      = (state_q == COLLECT) && bus.i_valid;
        last_accept = accept && (cnt_q == LAST_IDX);
        handshake   = valid_q && bus.i_ready;
        sel_idx     = (state_q == EMIT) ? CNT_W'(idx_q + 1'b1) : '0;
        recip_sel   = (state_q == EMIT) ? recip_q : div_quotient;
        prod        = PROD_W'(vec_buf_q[sel_idx]) * PROD_W'(recip_sel);
        scaled      = prod >> FRAC_BITS;
        prob_d      = (scaled > PROD_W'(ONE_Q412)) ? BIT_WIDTH'(ONE_Q412)
                                                   : scaled[BIT_WIDTH-1:0];
    end

    assign bus.o_in_ready = in_ready_q;
    assign bus.o_drop     = drop_q;
    assign bus.o_prob     = prob_q;
    assign bus.o_valid    = valid_q;
    assign bus.o_last     = last_q;

    // Control FSM with registered outputs, buffer and accumulator
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= COLLECT;
            cnt_q      <= '0;
            idx_q      <= '0;
            sum_q      <= '0;
            recip_q    <= '0;
            in_ready_q <= 1'b1;
            drop_q     <= 1'b0;
            prob_q     <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            for (int i = 0; i < VEC_LEN; i++) begin
                vec_buf_q[i] <= '0;
            end
        end else begin
            drop_q <= bus.i_valid && !in_ready_q;
            case (state_q)
                COLLECT: begin
                    if (accept) begin
                        vec_buf_q[cnt_q] <= exp_clamped;
                        sum_q            <= sum_d;
                        cnt_q            <= cnt_q + 1'b1;
                        if (last_accept) begin
                            state_q    <= DIVIDE;
                            in_ready_q <= 1'b0;
                        end
                    end
                end
                DIVIDE: begin
                    if (div_done) begin
                        recip_q <= div_quotient;
                        prob_q  <= prob_d;
                        valid_q <= 1'b1;
                        last_q  <= 1'b0;
                        idx_q   <= '0;
                        state_q <= EMIT;
                    end else if (!div_busy) begin
                        // Divider idle without finishing: abandon the vector
                        state_q    <= COLLECT;
                        in_ready_q <= 1'b1;
                        cnt_q      <= '0;
                        sum_q      <= '0;
                    end
                end
                EMIT: begin
                    if (handshake) begin
                        if (last_q) begin
                            state_q    <= COLLECT;
                            valid_q    <= 1'b0;
                            last_q     <= 1'b0;
                            in_ready_q <= 1'b1;
                            cnt_q      <= '0;
                            sum_q      <= '0;
                        end else begin
                            prob_q <= prob_d;
                            idx_q  <= idx_q + 1'b1;
                            last_q <= (CNT_W'(idx_q + 1'b1) == LAST_IDX);
                        end
                    end
                end
                default: begin
                    state_q    <= COLLECT;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_softmax_normalizer.sv
// Self-checking bench for softmax_normalizer: directed vectors against a
// queue-based arithmetic model of the softmax normalization.
module tb_softmax_normalizer;
    import softmax_pkg::*;

    localparam int VL = 8;

    typedef struct {
        logic [15:0] prob;
        logic        last;
    } exp_t;

    logic i_clk = 1'b0;
    logic i_rst;

    softmax_normalizer_if #(.BIT_WIDTH(16)) bus ();

    softmax_normalizer dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    always #5 i_clk = ~i_clk;

    int          n_checks  = 0;
    int          n_fail    = 0;
    int          cyc       = 0;
    int          e0_cyc    = 0;
    int          drop_cnt  = 0;
    int          exp_drops = 0;
    int          rdy_mode  = 0;
    bit          lat_armed = 1'b0;
    bit          mon_en    = 1'b0;
    bit          hold_pending = 1'b0;
    logic [15:0] held_prob;
    logic        held_last;
    logic [15:0] vec [VL];
    exp_t        exp_q [$];
    exp_t        e;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic logic [24:0] model_recip(input longint unsigned sum);
        if (sum == 0) return 25'd0;
        return 25'((64'd1 << 24) / sum);
    endfunction

    function automatic logic [15:0] model_prob(input logic [15:0] x, input logic [24:0] r);
        longint unsigned p;
        p = (64'(x) * 64'(r)) >> 12;
        return (p > 64'd4096) ? 16'h1000 : 16'(p);
    endfunction

    task automatic model_vector();
        longint unsigned sum = 0;
        logic [15:0]     xs [VL];
        logic [24:0]     r;
        exp_t            t;
        for (int i = 0; i < VL; i++) begin
            xs[i] = vec[i][15] ? 16'h0000 : vec[i];
            sum += 64'(xs[i]);
        end
        r = model_recip(sum);
        for (int i = 0; i < VL; i++) begin
            t.prob = model_prob(xs[i], r);
            t.last = (i == VL - 1);
            exp_q.push_back(t);
        end
    endtask

    // Called just after a posedge; leaves the bench just after edge E0
    task automatic send_vector();
        model_vector();
        for (int i = 0; i < VL; i++) begin
            bus.i_valid = 1'b1;
            bus.i_exp   = vec[i];
            @(posedge i_clk);
            #1;
        end
        bus.i_valid = 1'b0;
        e0_cyc = cyc;
    endtask

    task automatic wait_drain();
        int n = 0;
        @(negedge i_clk);
        while ((exp_q.size() != 0 || bus.o_valid) && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        if (n >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic fill(input logic [15:0] v);
        for (int i = 0; i < VL; i++) vec[i] = v;
    endtask

    // Downstream ready: 0 = always ready, 1 = toggle each cycle, 2 = stalled
    initial begin
        forever begin
            @(posedge i_clk);
            #1;
            case (rdy_mode)
                1:       bus.i_ready = ~bus.i_ready;
                2:       bus.i_ready = 1'b0;
                default: bus.i_ready = 1'b1;
            endcase
        end
    end

    // Output monitor: scoreboard, hold-while-stalled, latency and drop count
    initial begin
        forever begin
            @(negedge i_clk);
            if (!i_rst && mon_en) begin
                if (bus.o_drop) drop_cnt++;
                if (lat_armed && bus.o_valid) begin
                    chk("latency", 32'(cyc - e0_cyc), 32'd25);
                    lat_armed = 1'b0;
                end
                if (bus.o_valid && hold_pending) begin
                    chk("hold_prob", 32'(bus.o_prob), 32'(held_prob));
                    chk("hold_last", 32'(bus.o_last), 32'(held_last));
                end
                if (bus.o_valid && bus.i_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_output: got 0x%0h expected none", bus.o_prob);
                    end else begin
                        e = exp_q.pop_front();
                        chk("prob", 32'(bus.o_prob), 32'(e.prob));
                        chk("last", 32'(bus.o_last), 32'(e.last));
                    end
                end
                hold_pending = bus.o_valid && !bus.i_ready;
                held_prob    = bus.o_prob;
                held_last    = bus.o_last;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 32'(bus.o_in_ready), 32'd1);
        chk({tag, "_drop"},     32'(bus.o_drop),     32'd0);
        chk({tag, "_prob"},     32'(bus.o_prob),     32'd0);
        chk({tag, "_valid"},    32'(bus.o_valid),    32'd0);
        chk({tag, "_last"},     32'(bus.o_last),     32'd0);
    endtask

    initial begin
        int n;
        bus.i_valid = 1'b0;
        bus.i_exp   = '0;
        bus.i_ready = 1'b1;
        i_rst       = 1'b1;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check_reset_outputs("reset");

        // Hand-computed anchors for the model arithmetic
        chk("pin_recip_8x1", 32'(model_recip(64'd32768)), 32'd512);
        chk("pin_recip_zero", 32'(model_recip(64'd0)), 32'd0);
        chk("pin_prob_7fff", 32'(model_prob(16'h7FFF, model_recip(64'd32774))), 32'h0FF7);
        chk("pin_prob_one", 32'(model_prob(16'h1000, model_recip(64'd4096))), 32'h1000);

        @(posedge i_clk);
        #1;
        i_rst  = 1'b0;
        mon_en = 1'b1;
        @(posedge i_clk);
        #1;

        // 8 x 1.0: every element 1/8, first output 25 cycles after E0
        fill(16'h1000);
        lat_armed = 1'b1;
        send_vector();
        wait_drain();

        // One-hot vector
        fill(16'h0000);
        vec[0] = 16'h1000;
        send_vector();
        wait_drain();

        // All-zero vector: reciprocal forced to zero
        fill(16'h0000);
        send_vector();
        wait_drain();

        // Large first element with toggling downstream ready
        fill(16'h0001);
        vec[0] = 16'h7FFF;
        rdy_mode = 1;
        send_vector();
        wait_drain();
        rdy_mode = 0;

        // Negative inputs count as zero
        for (int i = 0; i < VL; i++) vec[i] = (i < 4) ? 16'h8000 : 16'h1000;
        send_vector();
        wait_drain();

        // Samples offered during DIVIDE and EMIT are dropped and flagged
        vec = '{16'h0800, 16'h0400, 16'h0400, 16'h0800,
                16'h0800, 16'h0400, 16'h0400, 16'h0800};
        send_vector();
        for (int i = 0; i < 3; i++) begin
            bus.i_valid = 1'b1;
            bus.i_exp   = 16'h7FFF;
            @(posedge i_clk);
            #1;
        end
        bus.i_valid = 1'b0;
        exp_drops += 3;
        rdy_mode = 2;
        n = 0;
        while (!bus.o_valid && n < 60) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        if (n >= 60) begin
            n_checks++;
            n_fail++;
            $display("FAIL emit_timeout: got o_valid 0 expected 1");
        end
        for (int i = 0; i < 2; i++) begin
            bus.i_valid = 1'b1;
            bus.i_exp   = 16'h7FFF;
            @(posedge i_clk);
            #1;
        end
        bus.i_valid = 1'b0;
        exp_drops += 2;
        repeat (2) @(posedge i_clk);
        #1;
        rdy_mode = 0;
        wait_drain();
        chk("drop_count", 32'(drop_cnt), 32'(exp_drops));

        // Next vector collected normally after the drops
        fill(16'h0100);
        send_vector();
        wait_drain();

        // Reset on divider step 10 abandons the vector
        fill(16'h1000);
        send_vector();
        repeat (9) @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        @(negedge i_clk);
        check_reset_outputs("midreset");
        exp_q.delete();
        hold_pending = 1'b0;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;
        fill(16'h1000);
        send_vector();
        wait_drain();

        chk("leftover_expected", 32'(exp_q.size()), 32'd0);
        chk("final_drop_count", 32'(drop_cnt), 32'(exp_drops));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
